// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and constants for the paced VT/CT sampling scheduler.
package adc_sched_pkg;

  localparam int SAMPLE_IDX_W = 9;

  localparam logic [6:0] XADC_ADDR_VAUX6 = 7'h16;
  localparam logic [6:0] XADC_ADDR_VAUX7 = 7'h17;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t S_IDLE    = 3'd0;
  localparam sched_state_t S_RD_VT   = 3'd1;
  localparam sched_state_t S_WAIT_VT = 3'd2;
  localparam sched_state_t S_RD_CT   = 3'd3;
  localparam sched_state_t S_WAIT_CT = 3'd4;
  localparam sched_state_t S_ISSUE   = 3'd5;

endpackage

// File: rtl/adc_sample_scheduler_tick_gen.sv
// Sample-rate tick generator: free-running 0..CLK_DIV-1 counter gated by en.
module sched_tick_gen #(
  parameter int CLK_DIV = 97656
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paced VT/CT DRP reader issuing time-aligned sample pairs to two FFT engines.
// Optional DRP wait timeout enabled by defining SCHED_TIMEOUT_EN.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int         CLK_DIV     = 97656,
  parameter int         DATA_W      = 16,
  parameter logic [6:0] ADDR_VT     = XADC_ADDR_VAUX6,
  parameter logic [6:0] ADDR_CT     = XADC_ADDR_VAUX7,
  parameter int         DRP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr_flags,
  output logic [6:0]              drp_daddr,
  output logic                    drp_den,
  input  logic                    drp_drdy,
  input  logic [DATA_W-1:0]       drp_do,
  output logic [DATA_W-1:0]       vt_sample,
  output logic [DATA_W-1:0]       ct_sample,
  output logic                    vt_start,
  output logic                    ct_start,
  output logic [SAMPLE_IDX_W-1:0] sample_idx,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  logic tick;

  sched_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  sched_state_t            state_q, state_d;
  logic [DATA_W-1:0]       vt_hold_q, vt_hold_d;
  logic [DATA_W-1:0]       ct_hold_q, ct_hold_d;
  logic [DATA_W-1:0]       vt_sample_q, vt_sample_d;
  logic [DATA_W-1:0]       ct_sample_q, ct_sample_d;
  logic [6:0]              daddr_q, daddr_d;
  logic                    den_q, den_d;
  logic                    start_q, start_d;
  logic [SAMPLE_IDX_W-1:0] idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(DRP_TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_evt;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    vt_hold_d = vt_hold_q;
    ct_hold_d = ct_hold_q;
`ifdef SCHED_TIMEOUT_EN
    timeout_evt = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_RD_VT;
      end
      S_RD_VT: state_d = S_WAIT_VT;
      S_WAIT_VT: begin
        if (drp_drdy) begin
          vt_hold_d = drp_do;
          state_d   = S_RD_CT;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          timeout_evt = 1'b1;
          state_d     = S_IDLE;
        end
`endif
      end
      S_RD_CT: state_d = S_WAIT_CT;
      S_WAIT_CT: begin
        if (drp_drdy) begin
          ct_hold_d = drp_do;
          state_d   = S_ISSUE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          timeout_evt = 1'b1;
          state_d     = S_IDLE;
        end
`endif
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    den_d   = (state_d == S_RD_VT) || (state_d == S_RD_CT);
    daddr_d = daddr_q;
    if (state_d == S_RD_VT) daddr_d = ADDR_VT;
    if (state_d == S_RD_CT) daddr_d = ADDR_CT;

    start_d     = (state_d == S_ISSUE);
    vt_sample_d = start_d ? vt_hold_d : vt_sample_q;
    ct_sample_d = start_d ? ct_hold_d : ct_sample_q;
    idx_d       = start_d ? idx_q + 1'b1 : idx_q;
    busy_d      = (state_d != S_IDLE);

    // A new flag event outranks a simultaneous clear.
    overrun_d = overrun_q;
    if (tick && state_q != S_IDLE) begin
      overrun_d = 1'b1;
    end else if (clr_flags) begin
      overrun_d = 1'b0;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_comb begin
    wait_cnt_d = 8'd0;
    if ((state_q == S_WAIT_VT || state_q == S_WAIT_CT) && !drp_drdy) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    timeout_d = timeout_q;
    if (timeout_evt) begin
      timeout_d = 1'b1;
    end else if (clr_flags) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      den_q       <= 1'b0;
      daddr_q     <= ADDR_VT;
      start_q     <= 1'b0;
      vt_sample_q <= '0;
      ct_sample_q <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      den_q       <= den_d;
      daddr_q     <= daddr_d;
      start_q     <= start_d;
      vt_sample_q <= vt_sample_d;
      ct_sample_q <= ct_sample_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Holding registers only feed the outputs at issue time, so they need no reset.
  always_ff @(posedge clk) begin
    vt_hold_q <= vt_hold_d;
    ct_hold_q <= ct_hold_d;
  end

  assign drp_den    = den_q;
  assign drp_daddr  = daddr_q;
  assign vt_start   = start_q;
  assign ct_start   = start_q;
  assign vt_sample  = vt_sample_q;
  assign ct_sample  = ct_sample_q;
  assign sample_idx = idx_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
